// File: rtl/online_mult_seq_pkg.sv
// Shared encodings for the online multiplier sequencer: slice STATE values,
// signed-digit codes and digit canonicalisation.
package online_mult_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_INIT    = 2'b01,
    ST_COMPUTE = 2'b10,
    ST_DRAIN   = 2'b11
  } state_t;

  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;

  // The unused code 11 carries no meaning, so it collapses to zero.
  function automatic logic [1:0] canon_digit(input logic [1:0] d);
    return (d == 2'b11) ? DIG_ZERO : d;
  endfunction

endpackage

// File: rtl/sd_prefix_reg.sv
// Accumulates a stream of signed digits, MSB first, into an MSB-aligned
// plus/minus prefix. clr restarts at the MSB position; en consumes one digit.
module sd_prefix_reg
  import online_mult_seq_pkg::*;
#(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [1:0]          digit,
  output logic [NUM_BITS-1:0] pre_plus,
  output logic [NUM_BITS-1:0] pre_minus
);

  logic [NUM_BITS-1:0] pos;
  logic [1:0]          dig_c;

  assign dig_c = canon_digit(digit);

  // pos is a one-hot write position walking from MSB to LSB; once it has
  // shifted out, further digits have nowhere to land and are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos       <= '0;
      pre_plus  <= '0;
      pre_minus <= '0;
    end else if (clr) begin
      pos       <= {1'b1, {(NUM_BITS-1){1'b0}}};
      pre_plus  <= '0;
      pre_minus <= '0;
    end else if (en) begin
      if (dig_c == DIG_POS) pre_plus  <= pre_plus | pos;
      if (dig_c == DIG_NEG) pre_minus <= pre_minus | pos;
      pos <= pos >> 1;
    end
  end

endmodule

// File: rtl/online_mult_seq.sv
// Sequencer for one MSB-first online signed-digit multiplication driving two
// digit-vector multiplier slices: digit selects, prefix vectors and STATE.
module online_mult_seq
  import online_mult_seq_pkg::*;
#(
  parameter int NUM_BITS     = 4,
  parameter int ONLINE_DELAY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] x_plus,
  input  logic [NUM_BITS-1:0] x_minus,
  input  logic [NUM_BITS-1:0] y_plus,
  input  logic [NUM_BITS-1:0] y_minus,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_out,
  output logic [1:0]          x_sel,
  output logic [1:0]          y_sel,
  output logic [NUM_BITS-1:0] xv_plus,
  output logic [NUM_BITS-1:0] xv_minus,
  output logic [NUM_BITS-1:0] yv_plus,
  output logic [NUM_BITS-1:0] yv_minus,
  output logic                step_valid,
  output logic                out_phase
);

  localparam int CNT_W = $clog2(NUM_BITS + ONLINE_DELAY + 1);
  localparam logic [CNT_W-1:0] LAST_ITER  = CNT_W'(NUM_BITS + ONLINE_DELAY - 1);
  localparam logic [CNT_W-1:0] DELAY_ITER = CNT_W'(ONLINE_DELAY);

  state_t              state;
  logic [CNT_W-1:0]    iter;
  logic [NUM_BITS-1:0] x_sh_p, x_sh_m, y_sh_p, y_sh_m;
  logic [NUM_BITS-1:0] x_can_p, x_can_m, y_can_p, y_can_m;
  logic [1:0]          y_sel_d;
  logic                accept;
  logic                active;

  // Handshake: start is accepted in any cycle with busy=0 (including the
  // done cycle) and ignored while busy=1; operands are sampled only then.
  assign accept = start && (state == ST_IDLE);
  assign active = (state == ST_INIT) || (state == ST_COMPUTE);
  assign busy      = (state != ST_IDLE);
  assign state_out = state;

  // Bitwise form of canon_digit applied across the whole operand.
  assign x_can_p = x_plus  & ~x_minus;
  assign x_can_m = x_minus & ~x_plus;
  assign y_can_p = y_plus  & ~y_minus;
  assign y_can_m = y_minus & ~y_plus;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      iter       <= '0;
      x_sh_p     <= '0;
      x_sh_m     <= '0;
      y_sh_p     <= '0;
      y_sh_m     <= '0;
      x_sel      <= DIG_ZERO;
      y_sel      <= DIG_ZERO;
      y_sel_d    <= DIG_ZERO;
      step_valid <= 1'b0;
      out_phase  <= 1'b0;
      done       <= 1'b0;
    end else begin
      // The slices register their select, so results trail the select by one.
      y_sel_d    <= y_sel;
      step_valid <= active;
      out_phase  <= active && (iter >= DELAY_ITER);
      done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_INIT;
            iter   <= '0;
            x_sel  <= {x_can_p[NUM_BITS-1], x_can_m[NUM_BITS-1]};
            y_sel  <= {y_can_p[NUM_BITS-1], y_can_m[NUM_BITS-1]};
            x_sh_p <= x_can_p << 1;
            x_sh_m <= x_can_m << 1;
            y_sh_p <= y_can_p << 1;
            y_sh_m <= y_can_m << 1;
          end
        end
        ST_INIT, ST_COMPUTE: begin
          if (iter == LAST_ITER) begin
            state <= ST_DRAIN;
            x_sel <= DIG_ZERO;
            y_sel <= DIG_ZERO;
          end else begin
            iter   <= iter + 1'b1;
            state  <= (iter + 1'b1 < DELAY_ITER) ? ST_INIT : ST_COMPUTE;
            x_sel  <= {x_sh_p[NUM_BITS-1], x_sh_m[NUM_BITS-1]};
            y_sel  <= {y_sh_p[NUM_BITS-1], y_sh_m[NUM_BITS-1]};
            x_sh_p <= x_sh_p << 1;
            x_sh_m <= x_sh_m << 1;
            y_sh_p <= y_sh_p << 1;
            y_sh_m <= y_sh_m << 1;
          end
        end
        ST_DRAIN: begin
          state <= ST_IDLE;
          iter  <= '0;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sd_prefix_reg #(.NUM_BITS(NUM_BITS)) u_x_prefix (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .en        (active),
    .digit     (x_sel),
    .pre_plus  (xv_plus),
    .pre_minus (xv_minus)
  );

  // Y lags X by one digit so a step forms x_i*Y[i-1] + y_i*X[i].
  sd_prefix_reg #(.NUM_BITS(NUM_BITS)) u_y_prefix (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .en        (step_valid),
    .digit     (y_sel_d),
    .pre_plus  (yv_plus),
    .pre_minus (yv_minus)
  );

endmodule

// File: tb/tb_online_mult_seq.sv
// Bench for online_mult_seq: scoreboard of per-cycle expected outputs for an
// N=4/delay=2 instance, plus count checks on an N=8/delay=3 instance.
module tb_online_mult_seq;

  localparam int N  = 4;
  localparam int D  = 2;
  localparam int T  = N + D;
  localparam int N8 = 8;
  localparam int D8 = 3;
  localparam int W  = 4 + 6 + 4 * N;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         start;
  logic [N-1:0] x_plus, x_minus, y_plus, y_minus;
  logic         busy, done, step_valid, out_phase;
  logic [1:0]   state_out, x_sel, y_sel;
  logic [N-1:0] xv_plus, xv_minus, yv_plus, yv_minus;
  logic [W-1:0] act_rec;

  logic          start_8;
  logic [N8-1:0] x_plus_8, x_minus_8, y_plus_8, y_minus_8;
  logic          busy_8, done_8, step_valid_8, out_phase_8;
  logic [1:0]    state_out_8, x_sel_8, y_sel_8;
  logic [N8-1:0] xv_plus_8, xv_minus_8, yv_plus_8, yv_minus_8;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  online_mult_seq #(.NUM_BITS(N), .ONLINE_DELAY(D)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_plus(x_plus), .x_minus(x_minus), .y_plus(y_plus), .y_minus(y_minus),
    .busy(busy), .done(done), .state_out(state_out),
    .x_sel(x_sel), .y_sel(y_sel),
    .xv_plus(xv_plus), .xv_minus(xv_minus), .yv_plus(yv_plus), .yv_minus(yv_minus),
    .step_valid(step_valid), .out_phase(out_phase)
  );

  online_mult_seq #(.NUM_BITS(N8), .ONLINE_DELAY(D8)) dut_8 (
    .clk(clk), .rst(rst), .start(start_8),
    .x_plus(x_plus_8), .x_minus(x_minus_8), .y_plus(y_plus_8), .y_minus(y_minus_8),
    .busy(busy_8), .done(done_8), .state_out(state_out_8),
    .x_sel(x_sel_8), .y_sel(y_sel_8),
    .xv_plus(xv_plus_8), .xv_minus(xv_minus_8), .yv_plus(yv_plus_8), .yv_minus(yv_minus_8),
    .step_valid(step_valid_8), .out_phase(out_phase_8)
  );

  assign act_rec = {busy, done, step_valid, out_phase, state_out, x_sel, y_sel,
                    xv_plus, xv_minus, yv_plus, yv_minus};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: digit k (0 = most significant) and the first k digits.
  function automatic logic [1:0] digit_at(input logic [N-1:0] p, input logic [N-1:0] m, input int k);
    if (k < 0 || k >= N) return 2'b00;
    return {p[N-1-k], m[N-1-k]};
  endfunction

  function automatic logic [N-1:0] prefix(input logic [N-1:0] v, input int k);
    int kk;
    int mask;
    kk = (k < 0) ? 0 : ((k > N) ? N : k);
    mask = ((1 << kk) - 1) << (N - kk);
    return v & mask[N-1:0];
  endfunction

  task automatic push_expected(input logic [N-1:0] xp, input logic [N-1:0] xm,
                               input logic [N-1:0] yp, input logic [N-1:0] ym);
    logic [N-1:0] cxp, cxm, cyp, cym;
    logic [1:0] st, xs, ys;
    logic bsy, dn, sv, op;
    cxp = xp & ~xm; cxm = xm & ~xp;
    cyp = yp & ~ym; cym = ym & ~yp;
    for (int c = 1; c <= T + 2; c++) begin
      bsy = (c <= T + 1);
      dn  = (c == T + 2);
      sv  = (c >= 2) && (c <= T + 1);
      op  = sv && (c - 2 >= D);
      st  = (c <= D) ? 2'b01 : (c <= T) ? 2'b10 : (c == T + 1) ? 2'b11 : 2'b00;
      xs  = (c <= T) ? digit_at(cxp, cxm, c - 1) : 2'b00;
      ys  = (c <= T) ? digit_at(cyp, cym, c - 1) : 2'b00;
      exp_q.push_back({bsy, dn, sv, op, st, xs, ys,
                       prefix(cxp, c - 1), prefix(cxm, c - 1),
                       prefix(cyp, c - 2), prefix(cym, c - 2)});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [N-1:0] xp, input logic [N-1:0] xm,
                       input logic [N-1:0] yp, input logic [N-1:0] ym);
    start = 1'b1;
    x_plus = xp; x_minus = xm; y_plus = yp; y_minus = ym;
    push_expected(xp, xm, yp, ym);
    @(posedge clk);
    #1;
    start = 1'b0;
    x_plus = N'($urandom); x_minus = N'($urandom);
    y_plus = N'($urandom); y_minus = N'($urandom);
  endtask

  task automatic issue_random();
    issue(N'($urandom), N'($urandom), N'($urandom), N'($urandom));
  endtask

  // A start while busy must be ignored, so nothing is pushed.
  task automatic poke();
    start = 1'b1;
    x_plus = N'($urandom); x_minus = N'($urandom);
    y_plus = N'($urandom); y_minus = N'($urandom);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run8();
    logic [N8-1:0] xp, xm, yp, ym;
    int sv_cnt = 0;
    int op_cnt = 0;
    int done_cyc = -1;
    xp = N8'($urandom); xm = N8'($urandom) & ~xp;
    yp = N8'($urandom); ym = N8'($urandom) & ~yp;
    start_8 = 1'b1;
    x_plus_8 = xp; x_minus_8 = xm; y_plus_8 = yp; y_minus_8 = ym;
    @(posedge clk);
    #1;
    start_8 = 1'b0;
    for (int c = 1; c <= 30 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (step_valid_8) sv_cnt++;
      if (out_phase_8) op_cnt++;
      if (done_8) begin
        done_cyc = c;
        check("n8_busy_at_done", busy_8, 0);
        check("n8_xv_final", {xv_plus_8, xv_minus_8}, {xp, xm});
        check("n8_yv_final", {yv_plus_8, yv_minus_8}, {yp, ym});
      end
      @(posedge clk);
      #1;
    end
    check("n8_done_cycle", done_cyc, N8 + D8 + 2);
    check("n8_step_valid_count", sv_cnt, N8 + D8);
    check("n8_out_phase_count", op_cnt, N8);
    idle(2);
  endtask

  // Monitor: every active cycle pops one expected record.
  initial begin
    logic [W-1:0] exp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy || done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_activity", {busy, done}, 2'b00);
          end else begin
            exp = exp_q.pop_front();
            check("cycle_rec", act_rec, exp);
          end
        end else begin
          check("idle_outputs", {step_valid, out_phase, state_out, x_sel, y_sel}, 0);
        end
      end
    end
  end

  initial begin
    start = 1'b0; x_plus = '0; x_minus = '0; y_plus = '0; y_minus = '0;
    start_8 = 1'b0; x_plus_8 = '0; x_minus_8 = '0; y_plus_8 = '0; y_minus_8 = '0;
    #1 rst = 1'b1;
    #2;
    check("reset_state", act_rec, 0);
    check("reset_state_n8", {busy_8, done_8, step_valid_8, out_phase_8, state_out_8,
                             x_sel_8, y_sel_8}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Directed operands, ignored starts at cycles 3 and 5, back-to-back at 8.
    issue(4'b1001, 4'b0010, 4'b0100, 4'b1000);
    idle(2);
    poke();
    idle(1);
    poke();
    idle(2);
    issue_random();
    idle(T + 4);

    // Illegal 11 digit in X.
    issue(4'b1100, 4'b0100, N'($urandom), N'($urandom));
    idle(T + 4);

    // Asynchronous abort in cycle 4.
    issue_random();
    idle(3);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", act_rec, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    issue_random();
    idle(T + 4);

    // Random operands with random gaps, gap 0 being back-to-back.
    for (int k = 0; k < 8; k++) begin
      issue_random();
      idle(T + 1 + $urandom_range(0, 3));
    end
    idle(T + 4);
    check("queue_drained", exp_q.size(), 0);

    for (int k = 0; k < 3; k++) run8();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
